// File: rtl/memgame_pkg.sv
// Shared definitions for the memory-game sequence player and the player-input checker:
// FSM state encoding, LFSR seed default and taps, and symbol decode helpers.
package memgame_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_ON   = 3'd2,
        ST_GAP  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    localparam logic [15:0] LFSR_DEFAULT = 16'hACE1;

    // Fibonacci feedback taps, shifted into bit 0
    localparam int TAP_A = 15;
    localparam int TAP_B = 13;
    localparam int TAP_C = 12;
    localparam int TAP_D = 10;

    function automatic logic [15:0] lfsr_next(input logic [15:0] q);
        return {q[14:0], q[TAP_A] ^ q[TAP_B] ^ q[TAP_C] ^ q[TAP_D]};
    endfunction

    // An all-zero state would lock the LFSR, so zero selects the default seed
    function automatic logic [15:0] seed_fix(input logic [15:0] seed);
        return (seed == 16'h0000) ? LFSR_DEFAULT : seed;
    endfunction

    function automatic logic [1:0] lfsr_sym(input logic [15:0] q);
        return q[1:0];
    endfunction

    function automatic logic [3:0] sym2onehot(input logic [1:0] sym);
        return 4'b0001 << sym;
    endfunction

endpackage

// File: rtl/sequence_player_lfsr16.sv
// 16-bit Fibonacci LFSR with synchronous load; shared by the player and the input checker
// so that both regenerate the identical symbol sequence from one seed.
module lfsr16
    import memgame_pkg::*;
(
    input  logic        Clk,
    input  logic        Rst,
    input  logic        load,
    input  logic        step,
    input  logic [15:0] din,
    output logic [15:0] q
);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            q <= LFSR_DEFAULT;
        end else if (load) begin
            q <= din;
        end else if (step) begin
            q <= lfsr_next(q);
        end
    end

endmodule

// File: rtl/sequence_player.sv
// Plays a seeded pseudo-random symbol sequence on four one-hot LEDs, paced by the game tick.
// Build option: define SEQ_PLAYER_GAP_EN for tick-timed blanks, otherwise blanks last one clock.
module sequence_player
    import memgame_pkg::*;
#(
    parameter int MAX_LEN   = 16,
    parameter int LEN_W     = 5,
    parameter int ON_TICKS  = 5,
    parameter int GAP_TICKS = 2
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             tick,
    input  logic             start,
    input  logic             abort,
    input  logic [LEN_W-1:0] level,
    input  logic [15:0]      seed,
    output logic [3:0]       led,
    output logic             busy,
    output logic             done
);

    localparam int TICK_W = $clog2(ON_TICKS + GAP_TICKS + 1);
    localparam logic [TICK_W-1:0] ON_LAST = TICK_W'(ON_TICKS - 1);
`ifdef SEQ_PLAYER_GAP_EN
    localparam logic [TICK_W-1:0] GAP_LAST = TICK_W'(GAP_TICKS - 1);
`endif

    state_t            state;
    logic [LEN_W-1:0]  len;
    logic [LEN_W-1:0]  len_eff;
    logic [LEN_W-1:0]  sym_cnt;
    logic [TICK_W-1:0] tick_cnt;
    logic [15:0]       seed_eff;
    logic [15:0]       lfsr_q;
    logic              lfsr_load;
    logic              lfsr_step;
    logic              on_end;

    assign seed_eff  = seed_fix(seed);
    assign on_end    = (state == ST_ON) && tick && (tick_cnt == ON_LAST);
    assign lfsr_load = (state == ST_LOAD) && !abort;
    assign lfsr_step = on_end && !abort;

    // NOTE: default assignment first keeps this combinational block free of inferred latches.
    always_comb begin
        len_eff = level;
        if (level == '0) begin
            len_eff = LEN_W'(1);
        end else if (level > LEN_W'(MAX_LEN)) begin
            len_eff = LEN_W'(MAX_LEN);
        end
    end

    lfsr16 u_lfsr (
        .Clk  (Clk),
        .Rst  (Rst),
        .load (lfsr_load),
        .step (lfsr_step),
        .din  (seed_eff),
        .q    (lfsr_q)
    );

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state    <= ST_IDLE;
            led      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            len      <= '0;
            sym_cnt  <= '0;
            tick_cnt <= '0;
        end else if (abort) begin
            state    <= ST_IDLE;
            led      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            sym_cnt  <= '0;
            tick_cnt <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    led <= '0;
                    if (start) begin
                        state <= ST_LOAD;
                        busy  <= 1'b1;
                    end
                end

                ST_LOAD: begin
                    len      <= len_eff;
                    sym_cnt  <= '0;
                    tick_cnt <= '0;
                    // LFSR loads on this same edge, so decode the first symbol from the seed itself
                    led      <= sym2onehot(lfsr_sym(seed_eff));
                    state    <= ST_ON;
                end

                ST_ON: begin
                    if (tick) begin
                        if (tick_cnt == ON_LAST) begin
                            tick_cnt <= '0;
                            sym_cnt  <= sym_cnt + LEN_W'(1);
                            led      <= '0;
                            if (sym_cnt == len - LEN_W'(1)) begin
                                state <= ST_DONE;
                                done  <= 1'b1;
                            end else begin
                                state <= ST_GAP;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + TICK_W'(1);
                        end
                    end
                end

                ST_GAP: begin
`ifdef SEQ_PLAYER_GAP_EN
                    if (tick) begin
                        if (tick_cnt == GAP_LAST) begin
                            tick_cnt <= '0;
                            led      <= sym2onehot(lfsr_sym(lfsr_q));
                            state    <= ST_ON;
                        end else begin
                            tick_cnt <= tick_cnt + TICK_W'(1);
                        end
                    end
`else
                    led   <= sym2onehot(lfsr_sym(lfsr_q));
                    state <= ST_ON;
`endif
                end

                ST_DONE: begin
                    led   <= '0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end

                default: begin
                    led   <= '0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sequence_player.sv
// Self-checking bench for sequence_player: table of playback scenarios plus hand-written
// reset, abort and start/abort priority sequences.
module tb_sequence_player;

    localparam int ON_TICKS  = 5;
    localparam int GAP_TICKS = 2;
`ifdef SEQ_PLAYER_GAP_EN
    localparam bit GAP_EN = 1'b1;
`else
    localparam bit GAP_EN = 1'b0;
`endif

    logic        Clk = 1'b0;
    logic        Rst;
    logic        tick;
    logic        start;
    logic        abort;
    logic [4:0]  level;
    logic [15:0] seed;
    logic [3:0]  led;
    logic        busy;
    logic        done;

    int total = 0;
    int bad   = 0;

    sequence_player #(
        .MAX_LEN   (16),
        .LEN_W     (5),
        .ON_TICKS  (ON_TICKS),
        .GAP_TICKS (GAP_TICKS)
    ) dut (
        .Clk   (Clk),
        .Rst   (Rst),
        .tick  (tick),
        .start (start),
        .abort (abort),
        .level (level),
        .seed  (seed),
        .led   (led),
        .busy  (busy),
        .done  (done)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] lfsr_adv(input logic [15:0] q);
        return {q[14:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
    endfunction

    typedef struct {
        logic [15:0] seed;
        logic [4:0]  level;
        int          period;       // tick every Nth cycle
        int          start_at;     // cycle of a stray start pulse, 0 = none
        int          exp_len;
        logic [3:0]  exp_first;
        int          exp_done_gap;
        int          exp_done_nogap;
    } vec_t;

    vec_t vecs[5];

    // Phase-list reference: each phase lasts a number of ticks or a number of clocks
    task automatic run_vec(input vec_t v, input int idx);
        int         need[$];
        bit         by_tick[$];
        logic [3:0] ph_led[$];
        bit         ph_done[$];
        logic [15:0] q;
        int ph, cnt, dones, done_at;
        bit finished;

        q = (v.seed == 16'h0) ? 16'hACE1 : v.seed;
        need.push_back(1); by_tick.push_back(0); ph_led.push_back(4'b0); ph_done.push_back(0);
        for (int s = 0; s < v.exp_len; s++) begin
            need.push_back(ON_TICKS); by_tick.push_back(1);
            ph_led.push_back(4'b0001 << q[1:0]); ph_done.push_back(0);
            q = lfsr_adv(q);
            if (s != v.exp_len - 1) begin
                need.push_back(GAP_EN ? GAP_TICKS : 1); by_tick.push_back(GAP_EN);
                ph_led.push_back(4'b0); ph_done.push_back(0);
            end
        end
        need.push_back(1); by_tick.push_back(0); ph_led.push_back(4'b0); ph_done.push_back(1);

        @(negedge Clk);
        start = 1'b1; abort = 1'b0; level = v.level; seed = v.seed;
        tick  = (v.period == 1);
        @(posedge Clk);
        ph = 0; cnt = 0; dones = 0; done_at = -1; finished = 1'b0;
        for (int c = 1; c < 400; c++) begin
            @(negedge Clk);
            if (ph < need.size()) begin
                check($sformatf("v%0d c%0d led", idx, c), led, ph_led[ph]);
                check($sformatf("v%0d c%0d busy", idx, c), busy, 1);
                check($sformatf("v%0d c%0d done", idx, c), done, ph_done[ph]);
            end else begin
                check($sformatf("v%0d c%0d idle led", idx, c), led, 0);
                check($sformatf("v%0d c%0d idle busy", idx, c), busy, 0);
                check($sformatf("v%0d c%0d idle done", idx, c), done, 0);
            end
            if (done === 1'b1) begin
                dones++;
                done_at = c;
            end
            if (c == 2) check($sformatf("v%0d first led", idx), led, v.exp_first);
            if (idx == 0 && v.period == 1 && c == 9)  check("v0 second symbol", led, 4'b0100);
            if (idx == 0 && v.period == 1 && c == 16) check("v0 third symbol", led, 4'b0001);
            if (ph >= need.size()) begin
                finished = 1'b1;
                break;
            end
            start = (c == v.start_at);
            if (c == 2) begin
                seed  = ~v.seed;
                level = 5'd7;
            end
            tick = ((c % v.period) == v.period - 1);
            @(posedge Clk);
            if (!by_tick[ph] || tick) cnt++;
            if (cnt == need[ph]) begin
                ph++;
                cnt = 0;
            end
        end
        start = 1'b0;
        tick  = 1'b0;
        check($sformatf("v%0d finished within budget", idx), finished, 1);
        check($sformatf("v%0d done count", idx), dones, 1);
        check($sformatf("v%0d done cycle", idx), done_at,
              GAP_EN ? v.exp_done_gap : v.exp_done_nogap);
    endtask

    initial begin
        int dones;

        vecs[0] = '{16'h0001, 5'd3,  1, 0,  3,  4'b0010, 21,  19};
        vecs[1] = '{16'h0001, 5'd3,  4, 0,  3,  4'b0010, 76,  60};
        vecs[2] = '{16'h0000, 5'd0,  1, 0,  1,  4'b0010, 7,   7};
        vecs[3] = '{16'h1234, 5'd20, 1, 10, 16, 4'b0001, 112, 97};
        vecs[4] = '{16'hBEEF, 5'd2,  1, 0,  2,  4'b1000, 14,  13};

        Rst = 1'b0; tick = 1'b0; start = 1'b0; abort = 1'b0; level = '0; seed = '0;
        #12;
        check("reset led", led, 0);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        @(negedge Clk);
        Rst = 1'b1;

        // Asynchronous reset in the middle of the first symbol
        @(negedge Clk);
        start = 1'b1; seed = 16'h0001; level = 5'd3; tick = 1'b1;
        @(negedge Clk);
        start = 1'b0;
        repeat (3) @(negedge Clk);
        check("pre-reset busy", busy, 1);
        check("pre-reset led", led, 4'b0010);
        Rst = 1'b0;
        #1;
        check("mid-on reset led", led, 0);
        check("mid-on reset busy", busy, 0);
        check("mid-on reset done", done, 0);
        @(negedge Clk);
        Rst = 1'b1;
        tick = 1'b0;

        for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

        // Abort during the second symbol
        @(negedge Clk);
        start = 1'b1; seed = 16'h0001; level = 5'd3; tick = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        start = 1'b0;
        repeat (9) @(negedge Clk);
        check("abort second symbol led", led, 4'b0100);
        abort = 1'b1;
        @(negedge Clk);
        abort = 1'b0;
        check("abort led", led, 0);
        check("abort busy", busy, 0);
        check("abort done", done, 0);
        dones = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge Clk);
            if (done === 1'b1 || busy === 1'b1) dones++;
        end
        check("abort no done or restart", dones, 0);

        // abort and start together in IDLE: abort wins
        @(negedge Clk);
        start = 1'b1; abort = 1'b1;
        @(negedge Clk);
        start = 1'b0; abort = 1'b0;
        check("abort beats start busy", busy, 0);
        @(negedge Clk);
        check("abort beats start stays idle", busy, 0);
        check("abort beats start led", led, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
